mm3x3_mac_scheduler: RTL and testbench
======================================

Name: mm3x3_mac_scheduler

Overview:
Sequences one 3x3 matrix product C = A x B on a single shared MULTIPLIER instance.
- Loads A then B as a serial element stream.
- Issues 27 multiply-accumulates, one per cycle.
- Streams the 9 results out with valid/ready.
- Sits between the host-side operand stream and the result consumer. It is the only user of the multiplier datapath.

Parameters:
- WIDTH, 4: operand element width. It must equal 4, which is the width the shared MULTIPLIER supports; any other value is an elaboration-time error.
- ACC_W, 2*WIDTH+2: result width. Holds 3 x (2^WIDTH-1)^2 = 675 without overflow.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts an element.
- in_data  in  WIDTH  element, unsigned. Order is A row-major (9 beats), then B row-major (9 beats).
- out_valid  out  1  result element valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  C element, unsigned, row-major.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all counters 0, in_ready=1, out_valid=0, out_data=0, busy=0, done=0. Register-file contents are don't-care.
- Handshake: a transfer occurs on a cycle where valid & ready are both high. in_valid/in_data may gap freely.
- FSM states: IDLE, LOAD, COMPUTE, OUTPUT.
- IDLE:
  - in_ready=1.
  - First accepted beat is stored as A[0][0]; go to LOAD with load_cnt=1.
- LOAD:
  - in_ready=1; load_cnt (0..17) advances per accepted beat. Beats 0-8 fill A, beats 9-17 fill B.
  - The edge accepting beat 17 moves to COMPUTE with i=j=k=0.
- COMPUTE:
  - in_ready=0. Loop order: i outer, j, k inner.
  - Each cycle: product = A[i][k]*B[k][j] from the MULTIPLIER.
  - acc <= (k==0 ? 0 : acc) + product.
  - When k==2, write acc+product into C[i][j].
  - Exactly 27 cycles. On i=j=k=2, go to OUTPUT with out_idx=0.
- OUTPUT:
  - out_valid=1 and out_data=C[out_idx].
  - out_data is held stable while out_ready=0.
  - out_idx advances per handshake. The handshake at out_idx=8 moves to IDLE and asserts done for the following cycle.
  - in_ready=0 throughout; in_valid is ignored.
- Latency: first out_valid occurs 27 cycles after the edge that accepts beat 17.
- Arithmetic: all values are unsigned. Products are zero-extended to ACC_W. No saturation is needed because ACC_W is sized for the worst case.
- done and busy: done is high in the first IDLE cycle after completion. That cycle can already accept a new A[0][0] (back-to-back jobs). busy=0 in that cycle.
- Reset mid-operation: any state returns to IDLE immediately. Partial matrices and results are discarded, and out_valid drops asynchronously.
- Index wrap: load_cnt, k, j, i and out_idx all return to 0 on leaving their state. No counter exceeds its range.

Optional Feature:
- Macro: MM3X3_PIPE_MUL_EN.
- Defined: the multiplier output is registered before the accumulator. COMPUTE lasts 28 cycles (one drain cycle), and the C write is delayed one cycle alongside a registered k==2 flag. First out_valid occurs 28 cycles after the edge accepting beat 17. All other behaviour is identical.
- Undefined: the multiplier is combinational into the accumulator; 27 cycles.

Decomposition:
- Package mm3x3_pkg:
  - state enum {IDLE, LOAD, COMPUTE, OUTPUT}
  - N=3, ELEMS=9, LOAD_BEATS=18, MAC_CYCLES=27
  - ACC_W derivation function
- Sub-module mm3x3_idx_counter: nested i/j/k counter with enable, clear and last flag. It is instantiated once for COMPUTE.
- The existing MULTIPLIER is instantiated once.

Test Plan:
- Identity test: A=I, B=[1..9] row-major, out_ready=1 -> outputs 1,2,...,9. done pulses once. First out_valid 27 cycles after the last input (28 with MM3X3_PIPE_MUL_EN).
- Maximum values: all A and B elements = 15 -> all nine outputs = 675 (10'h2A3), no overflow.
- Backpressure: A=B=all 2s (outputs 12) with out_ready toggled 1,0,0,1,... -> out_data is stable while stalled, exactly 9 handshakes occur, and in_ready stays 0 until done.
- Bursty input: in_valid gaps of 1-3 cycles between beats -> result equals the gap-free run. in_ready=0 during COMPUTE and OUTPUT, and extra in_valid there is ignored.
- Reset mid-job: assert rst_n=0 at COMPUTE cycle 10 -> out_valid=0, busy=0, in_ready=1 immediately. The next full job then gives the correct product.
- Back-to-back jobs: start job 2 on the done cycle -> A[0][0] is accepted in that cycle and both result sets are correct.

Source files
------------

// File: rtl/mm3x3_pkg.sv
// mm3x3_pkg: shared types, sizes and helpers for the 3x3 matrix-product
// scheduler. Imported by mm3x3_idx_counter and mm3x3_mac_scheduler.
//   state_e   : scheduler FSM states
//   N/ELEMS/LOAD_BEATS/MAC_CYCLES : matrix geometry and phase lengths
//   MUL_WIDTH : operand width supported by the shared multiplier
//   acc_w_of  : accumulator width for a given operand width
//   elem_idx  : row-major flat index of element [row][col]
package mm3x3_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_e;

    localparam int N          = 3;
    localparam int ELEMS      = 9;
    localparam int LOAD_BEATS = 18;
    localparam int MAC_CYCLES = 27;
    localparam int MUL_WIDTH  = 4;

    // Three products of two full-scale operands need two extra bits.
    function automatic int acc_w_of(input int width);
        return 2 * width + 2;
    endfunction

    // row*3 + col, built from a shift and adds.
    function automatic logic [3:0] elem_idx(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col};
    endfunction

endpackage

// File: rtl/mm3x3_idx_counter.sv
// mm3x3_idx_counter: nested i/j/k loop counter, k innermost, each 0..2.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous return of all indices to 0 (has priority)
//   en         : advance one step; (2,2,2) wraps to (0,0,0)
//   i, j, k    : current indices (registered)
//   last       : high when i=j=k=2
module mm3x3_idx_counter
    import mm3x3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] i,
    output logic [1:0] j,
    output logic [1:0] k,
    output logic       last
);

    logic [1:0] i_r;
    logic [1:0] j_r;
    logic [1:0] k_r;

    // Index registers: k steps every enable, j on k wrap, i on j wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r <= 2'd0;
            j_r <= 2'd0;
            k_r <= 2'd0;
        end else if (clr) begin
            i_r <= 2'd0;
            j_r <= 2'd0;
            k_r <= 2'd0;
        end else if (en) begin
            if (k_r == 2'd2) begin
                k_r <= 2'd0;
                if (j_r == 2'd2) begin
                    j_r <= 2'd0;
                    i_r <= (i_r == 2'd2) ? 2'd0 : i_r + 2'd1;
                end else begin
                    j_r <= j_r + 2'd1;
                end
            end else begin
                k_r <= k_r + 2'd1;
            end
        end
    end

    assign i    = i_r;
    assign j    = j_r;
    assign k    = k_r;
    assign last = (i_r == 2'd2) && (j_r == 2'd2) && (k_r == 2'd2);

endmodule

// File: rtl/mm3x3_mul.sv
// mm3x3_mul: the shared unsigned 4x4 multiplier datapath.
// Ports:
//   a, b : 4-bit unsigned operands
//   p    : 8-bit unsigned product (combinational)
module mm3x3_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/mm3x3_mac_scheduler.sv
// mm3x3_mac_scheduler: computes one C = A x B (3x3, unsigned) on a single
// shared multiplier. A then B arrive row-major on the input stream, 27
// multiply-accumulates run one per cycle, then C streams out row-major.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand stream handshake, in_data = element
//   out_valid/out_ready : result stream handshake, out_data = C element
//   busy                : high whenever the FSM is not IDLE
//   done                : one-cycle pulse in the first IDLE cycle after a job
// Build option MM3X3_PIPE_MUL_EN: registers the multiplier output before the
// accumulator; COMPUTE then takes 28 cycles (one drain cycle).
module mm3x3_mac_scheduler
    import mm3x3_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ACC_W = acc_w_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             done
);

    generate
        if (WIDTH != MUL_WIDTH) begin : g_width_check
            $error("mm3x3_mac_scheduler: WIDTH must equal the multiplier width (4)");
        end
    endgenerate

    state_e             state_r;
    state_e             next_state_s;
    logic [4:0]         load_cnt_r;
    logic [3:0]         out_idx_r;
    logic [3:0]         out_nxt_idx_s;
    logic [3:0]         b_wr_idx_s;

    logic [WIDTH-1:0]   a_r [0:ELEMS-1];
    logic [WIDTH-1:0]   b_r [0:ELEMS-1];
    logic [ACC_W-1:0]   c_r [0:ELEMS-1];

    logic               in_ready_r;
    logic               out_valid_r;
    logic [ACC_W-1:0]   out_data_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               out_hs_s;
    logic               cnt_en_s;
    logic               cnt_clr_s;
    logic [1:0]         ci_s;
    logic [1:0]         cj_s;
    logic [1:0]         ck_s;
    logic               clast_s;

    logic [WIDTH-1:0]   mul_a_s;
    logic [WIDTH-1:0]   mul_b_s;
    logic [2*WIDTH-1:0] mul_p_s;
    logic [ACC_W-1:0]   prod_ext_s;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_base_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic               mac_en_s;
    logic               c_we_s;
    logic [3:0]         c_widx_s;

`ifdef MM3X3_PIPE_MUL_EN
    logic [ACC_W-1:0]   prod_r;
    logic               kz_r;
    logic               k2_r;
    logic [3:0]         cidx_r;
    logic               pv_r;
    logic               drain_r;
`endif

    assign accept_s      = in_valid && in_ready_r;
    assign out_hs_s      = out_valid_r && out_ready;
    assign out_nxt_idx_s = out_idx_r + 4'd1;
    // Beats 9..17 land in B[0..8]; the 4-bit subtraction wraps 16/17 to 7/8.
    assign b_wr_idx_s    = load_cnt_r[3:0] - 4'd9;

    mm3x3_idx_counter u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .i     (ci_s),
        .j     (cj_s),
        .k     (ck_s),
        .last  (clast_s)
    );

    assign mul_a_s = a_r[elem_idx(ci_s, ck_s)];
    assign mul_b_s = b_r[elem_idx(ck_s, cj_s)];

    mm3x3_mul u_mul (
        .a (mul_a_s),
        .b (mul_b_s),
        .p (mul_p_s)
    );

    assign prod_ext_s = ACC_W'(mul_p_s);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state and loop-counter control.
    always_comb begin
        next_state_s = state_r;
        cnt_en_s     = 1'b0;
        cnt_clr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_clr_s = 1'b1;
                if (accept_s) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                cnt_clr_s = 1'b1;
                if (accept_s && (load_cnt_r == 5'(LOAD_BEATS - 1))) begin
                    next_state_s = COMPUTE;
                end else begin
                    next_state_s = LOAD;
                end
            end
            COMPUTE: begin
`ifdef MM3X3_PIPE_MUL_EN
                if (drain_r) begin
                    cnt_clr_s    = 1'b1;
                    next_state_s = OUTPUT;
                end else begin
                    cnt_en_s     = 1'b1;
                    next_state_s = COMPUTE;
                end
`else
                cnt_en_s = 1'b1;
                if (clast_s) begin
                    next_state_s = OUTPUT;
                end else begin
                    next_state_s = COMPUTE;
                end
`endif
            end
            OUTPUT: begin
                cnt_clr_s = 1'b1;
                if (out_hs_s && (out_idx_r == 4'(ELEMS - 1))) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = OUTPUT;
                end
            end
            default: begin
                cnt_clr_s    = 1'b1;
                next_state_s = IDLE;
            end
        endcase
    end

    // Load beat counter: 0..17 across IDLE/LOAD, back to 0 after beat 17.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_r <= 5'd0;
        end else if (accept_s) begin
            load_cnt_r <= (load_cnt_r == 5'(LOAD_BEATS - 1)) ? 5'd0 : load_cnt_r + 5'd1;
        end else if ((state_r != IDLE) && (state_r != LOAD)) begin
            load_cnt_r <= 5'd0;
        end
    end

    // Operand register file: beats 0-8 fill A, beats 9-17 fill B.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            if (load_cnt_r < 5'd9) begin
                a_r[load_cnt_r[3:0]] <= in_data;
            end else begin
                b_r[b_wr_idx_s] <= in_data;
            end
        end
    end

`ifdef MM3X3_PIPE_MUL_EN
    // Product register plus the k-position and C-index that travel with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r  <= {ACC_W{1'b0}};
            kz_r    <= 1'b0;
            k2_r    <= 1'b0;
            cidx_r  <= 4'd0;
            pv_r    <= 1'b0;
            drain_r <= 1'b0;
        end else begin
            prod_r  <= prod_ext_s;
            kz_r    <= (ck_s == 2'd0);
            k2_r    <= (ck_s == 2'd2);
            cidx_r  <= elem_idx(ci_s, cj_s);
            pv_r    <= (state_r == COMPUTE) && !drain_r;
            drain_r <= (state_r == COMPUTE) && !drain_r && clast_s;
        end
    end

    // Accumulate the registered product one cycle behind the index counter.
    always_comb begin
        acc_base_s = kz_r ? {ACC_W{1'b0}} : acc_r;
        acc_sum_s  = acc_base_s + prod_r;
        mac_en_s   = pv_r;
        c_we_s     = pv_r && k2_r;
        c_widx_s   = cidx_r;
    end
`else
    // Accumulate the combinational product in the same cycle it is formed.
    always_comb begin
        acc_base_s = (ck_s == 2'd0) ? {ACC_W{1'b0}} : acc_r;
        acc_sum_s  = acc_base_s + prod_ext_s;
        mac_en_s   = (state_r == COMPUTE);
        c_we_s     = (state_r == COMPUTE) && (ck_s == 2'd2);
        c_widx_s   = elem_idx(ci_s, cj_s);
    end
`endif

    // Running dot-product accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (mac_en_s) begin
            acc_r <= acc_sum_s;
        end
    end

    // Result register file: the completed dot product lands on k==2.
    always_ff @(posedge clk) begin
        if (c_we_s) begin
            c_r[c_widx_s] <= acc_sum_s;
        end
    end

    // Result index: advances per output handshake, 0 outside OUTPUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_r <= 4'd0;
        end else if (state_r != OUTPUT) begin
            out_idx_r <= 4'd0;
        end else if (out_hs_s) begin
            out_idx_r <= (out_idx_r == 4'(ELEMS - 1)) ? 4'd0 : out_nxt_idx_s;
        end
    end

    // Registered handshake and status outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == IDLE) || (next_state_s == LOAD);
            out_valid_r <= (next_state_s == OUTPUT);
            busy_r      <= (next_state_s != IDLE);
            done_r      <= (state_r == OUTPUT) && (next_state_s == IDLE);
            if (next_state_s == OUTPUT) begin
                if (state_r != OUTPUT) begin
                    out_data_r <= c_r[4'd0];
                end else if (out_hs_s) begin
                    out_data_r <= c_r[out_nxt_idx_s];
                end else begin
                    out_data_r <= out_data_r;
                end
            end else begin
                out_data_r <= {ACC_W{1'b0}};
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_mm3x3_mac_scheduler.sv
// Bench for mm3x3_mac_scheduler: random and directed 3x3 products checked
// against a plain-arithmetic matrix product, with consumer backpressure,
// bursty input, mid-job resets and back-to-back jobs.
module tb_mm3x3_mac_scheduler;

    localparam int WIDTH = 4;
    localparam int ACC_W = 10;
`ifdef MM3X3_PIPE_MUL_EN
    localparam int LAT = 28;
`else
    localparam int LAT = 27;
`endif

    typedef int mat_t [9];

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             busy;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q [$];
    int out_cnt     = 0;
    int done_cnt    = 0;
    int jobs_done   = 0;
    int last_out [9];
    int rdy_mode    = 0;

    always #5 clk = ~clk;

    mm3x3_mac_scheduler #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Reference: plain matrix product, results pushed in row-major order.
    task automatic model(input mat_t a, input mat_t b);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int s;
                s = 0;
                for (int m = 0; m < 3; m++) s += a[r*3+m] * b[m*3+c];
                exp_q.push_back(s);
            end
        end
    endtask

    // Consumer: drives out_ready just after each rising edge.
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Compare process: checks every output handshake and stall cycle.
    initial begin
        int e;
        logic             stall_prev;
        logic [ACC_W-1:0] stall_data;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, stall_data);
                end
                if (out_valid) check("in_ready_in_output", in_ready, 0);
                if (done) begin
                    done_cnt++;
                    check("done_busy", busy, 0);
                    check("done_in_ready", in_ready, 1);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_out: got %0d, expected no result (t=%0t)", out_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e);
                        last_out[out_cnt % 9] = int'(out_data);
                    end
                    out_cnt++;
                end
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Offers one beat and returns just after the edge that accepts it.
    task automatic send_beat(input logic [WIDTH-1:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("send_beat");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    task automatic load_job(input mat_t a, input mat_t b, input int maxgap, input int first);
        for (int n = first; n < 18; n++) begin
            send_beat((n < 9) ? 4'(a[n]) : 4'(b[n-9]));
            if (n != 17) begin
                repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
            end
        end
        model(a, b);
    endtask

    // Counts cycles from the beat-17 edge to the first out_valid.
    task automatic await_first_out(input bit garbage);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int t = 0; t < LAT + 20; t++) begin
            check("in_ready_compute", in_ready, 0);
            if (garbage) begin in_valid = 1'b1; in_data = 4'($urandom); end
            @(posedge clk);
            #1;
            n++;
            if (out_valid) begin seen = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!seen) timeout("first_out_valid");
        else check("latency", n, LAT);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            if (done_cnt >= jobs_done + 1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("wait_done");
        jobs_done++;
        check("done_count", done_cnt, jobs_done);
        check("out_count", out_cnt, 9 * jobs_done);
        check("queue_empty", exp_q.size(), 0);
        check("done_one_cycle", done, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic do_reset_pulse();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_mat(output mat_t m);
        for (int q = 0; q < 9; q++) m[q] = $urandom_range(0, 15);
    endtask

    initial begin
        mat_t a;
        mat_t b;
        mat_t a2;
        mat_t b2;
        bit   ok;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity A, B = 1..9.
        a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        rdy_mode = 0;
        load_job(a, b, 0, 0);
        await_first_out(1'b0);
        wait_done();
        for (int q = 0; q < 9; q++) check("identity_out", last_out[q], q + 1);

        // Full-scale operands.
        for (int q = 0; q < 9; q++) begin a[q] = 15; b[q] = 15; end
        load_job(a, b, 0, 0);
        await_first_out(1'b0);
        wait_done();
        for (int q = 0; q < 9; q++) check("max_out", last_out[q], 32'h2A3);

        // Backpressure 1,0,0 with all-2 matrices.
        for (int q = 0; q < 9; q++) begin a[q] = 2; b[q] = 2; end
        rdy_mode = 1;
        load_job(a, b, 0, 0);
        await_first_out(1'b0);
        wait_done();
        for (int q = 0; q < 9; q++) check("bp_out", last_out[q], 12);

        // Bursty input with stray in_valid during COMPUTE.
        rdy_mode = 2;
        rand_mat(a);
        rand_mat(b);
        load_job(a, b, 3, 0);
        await_first_out(1'b1);
        wait_done();

        // Reset in the middle of COMPUTE, then a full job.
        rdy_mode = 0;
        rand_mat(a);
        rand_mat(b);
        load_job(a, b, 0, 0);
        repeat (10) begin @(posedge clk); #1; end
        check("mid_compute_busy", busy, 1);
        do_reset_pulse();
        rand_mat(a);
        rand_mat(b);
        load_job(a, b, 1, 0);
        await_first_out(1'b0);
        wait_done();

        // Reset while a result is stalled in OUTPUT.
        rdy_mode = 3;
        rand_mat(a);
        rand_mat(b);
        load_job(a, b, 0, 0);
        await_first_out(1'b0);
        repeat (2) begin @(posedge clk); #1; end
        check("stalled_valid", out_valid, 1);
        do_reset_pulse();
        rdy_mode = 0;

        // Back-to-back: job 2 starts on job 1's done cycle.
        rdy_mode = 2;
        rand_mat(a);
        rand_mat(b);
        rand_mat(a2);
        rand_mat(b2);
        load_job(a, b, 0, 0);
        await_first_out(1'b0);
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            if (out_cnt >= 9 * (jobs_done + 1)) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("b2b_job1");
        jobs_done++;
        in_valid = 1'b1;
        in_data  = 4'(a2[0]);
        @(negedge clk);
        check("b2b_done", done, 1);
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_busy", busy, 1);
        load_job(a2, b2, 0, 1);
        await_first_out(1'b0);
        wait_done();

        // Random jobs with mixed consumer behaviour.
        for (int r = 0; r < 4; r++) begin
            rdy_mode = r % 3;
            rand_mat(a);
            rand_mat(b);
            load_job(a, b, $urandom_range(0, 3), 0);
            await_first_out(1'b1);
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
